// File: rtl/snn_spike_aer_collector_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snn_spike_aer_collector_if: neuron-result in / AER word out bus  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface snn_spike_aer_collector_if #(
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_neuron;
  logic             in_spike;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  modport master (
    output in_valid, in_neuron, in_spike, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_neuron, in_spike, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/snn_spike_aer_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snn_spike_aer_collector: packs spikes into AER words, FWFT FIFO, |
// | end-of-timestep markers and bitmap publish. Rev 1.0              |
// +------------------------------------------------------------------+
module snn_spike_aer_collector #(
  parameter int NEURONS = 16,
  parameter int IDX_W   = 4,
  parameter int TS_W    = 12,
  parameter int DEPTH   = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  snn_spike_aer_collector_if.slave      bus,
  input  wire logic                     layer_done,
  input  wire logic                     ts_clear,
  output logic [NEURONS-1:0]            spike_map,
  output logic                          map_valid,
  output logic [TS_W-1:0]               timestep,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_EOT = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, push_req, push, pop;
  logic [31:0]        push_word;
  logic [NEURONS-1:0] work_map;
  logic [15:0]        spike_count;
  logic               spike_evt, eot_fire, ts_clr_req;

  always_comb begin
    state_nx   = state;
    push_req   = 1'b0;
    push_word  = '0;
    spike_evt  = 1'b0;
    eot_fire   = 1'b0;
    ts_clr_req = 1'b0;
    case (state)
      S_RUN: begin
        spike_evt = bus.in_valid && bus.in_spike;
        if (spike_evt) begin
          push_req  = 1'b1;
          push_word = {1'b0, 3'b000, timestep, {(16-IDX_W){1'b0}}, bus.in_neuron};
        end
        if (layer_done)
          state_nx = S_EOT;
        else if (ts_clear)
          ts_clr_req = 1'b1;
      end
      S_EOT: begin
        // Marker stalls rather than drops: it waits for a free slot.
        push_word = {1'b1, 3'b000, timestep, spike_count};
        if (!full) begin
          push_req = 1'b1;
          eot_fire = 1'b1;
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  assign full          = (count == CNT_W'(DEPTH));
  assign push          = push_req && !full;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = (state == S_RUN);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 32'd0;
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      work_map    <= '0;
      spike_count <= '0;
      timestep    <= '0;
      spike_map   <= '0;
      map_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state     <= state_nx;
      map_valid <= eot_fire;
      if (spike_evt && full)
        overflow <= 1'b1;
      if (eot_fire) begin
        spike_map   <= work_map;
        work_map    <= '0;
        spike_count <= '0;
        timestep    <= timestep + TS_W'(1);
      end else if (ts_clr_req) begin
        work_map    <= '0;
        spike_count <= '0;
        timestep    <= '0;
      end else if (spike_evt) begin
        work_map[bus.in_neuron] <= 1'b1;
        if (spike_count != 16'hFFFF)
          spike_count <= spike_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_spike_aer_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_snn_spike_aer_collector: directed vector bench for the AER    |
// | spike collector. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_snn_spike_aer_collector;

  localparam int NEURONS = 16;
  localparam int IDX_W   = 4;
  localparam int TS_W    = 12;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               layer_done;
  logic               ts_clear;
  logic [NEURONS-1:0] spike_map;
  logic               map_valid;
  logic [TS_W-1:0]    timestep;
  logic [4:0]         fifo_count;
  logic               overflow;

  snn_spike_aer_collector_if #(.IDX_W(IDX_W)) bus ();

  snn_spike_aer_collector #(
    .NEURONS(NEURONS), .IDX_W(IDX_W), .TS_W(TS_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .layer_done (layer_done),
    .ts_clear   (ts_clear),
    .spike_map  (spike_map),
    .map_valid  (map_valid),
    .timestep   (timestep),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] got [$];

  // Words that will be popped at the coming rising edge.
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      got.push_back(bus.out_data);

  typedef struct {
    logic        v;
    logic [3:0]  n;
    logic        s;
    logic        ld;
    logic        clr;
    logic [4:0]  e_cnt;
    logic        e_rdy;
    logic [11:0] e_ts;
    logic        e_mv;
    logic [15:0] e_map;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_words(input string name, input logic [31:0] exp [$]);
    chk({name, "_nwords"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_w%0d", name, i), (i < got.size()) ? got[i] : 32'hDEADBEEF, exp[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic s,
                       input logic ld, input logic clr);
    bus.in_valid  = v;
    bus.in_neuron = n;
    bus.in_spike  = s;
    layer_done    = ld;
    ts_clear      = clr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q [$];

    tbl[0] = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 12'd0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 12'd0, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 12'd0, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 12'd0, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 12'd1, 1'b1, 16'h8088};
    tbl[5] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 12'd1, 1'b0, 16'h8088};
    tbl[6] = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 12'd1, 1'b0, 16'h8088};
    tbl[7] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 12'd2, 1'b1, 16'h0020};
    tbl[8] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 12'd2, 1'b0, 16'h0020};

    bus.out_ready = 1'b0;
    do_reset();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_count",     32'(fifo_count),    32'd0);
    chk("rst_map",       32'(spike_map),     32'd0);
    chk("rst_map_valid", 32'(map_valid),     32'd0);
    chk("rst_timestep",  32'(timestep),      32'd0);
    chk("rst_overflow",  32'(overflow),      32'd0);

    // Basic events followed by a spike coincident with layer_done.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].n, tbl[i].s, tbl[i].ld, tbl[i].clr);
      step();
      chk($sformatf("v%0d_count", i),  32'(fifo_count),   32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_ready", i),  32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_ts", i),     32'(timestep),     32'(tbl[i].e_ts));
      chk($sformatf("v%0d_mvalid", i), 32'(map_valid),    32'(tbl[i].e_mv));
      chk($sformatf("v%0d_map", i),    32'(spike_map),    32'(tbl[i].e_map));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    exp_q = '{32'h00000003, 32'h00000007, 32'h0000000F, 32'h80000003,
              32'h00010005, 32'h80010001};
    chk_words("basic", exp_q);

    // Empty pass.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("empty_count", 32'(fifo_count), 32'd0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("empty_mvalid", 32'(map_valid), 32'd1);
    chk("empty_map",    32'(spike_map), 32'd0);
    chk("empty_ts",     32'(timestep),  32'd1);
    step();
    exp_q = '{32'h80000000};
    chk_words("empty", exp_q);

    // Backpressure and full FIFO.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      step();
      if (i == 15)
        chk("bp_ovf_before", 32'(overflow), 32'd0);
    end
    chk("bp_count_full", 32'(fifo_count), 32'd16);
    chk("bp_overflow",   32'(overflow),   32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("bp_eot_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_eot_count", 32'(fifo_count),   32'd16);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop1_count", 32'(fifo_count),   32'd15);
    chk("bp_pop1_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("bp_mark_count", 32'(fifo_count),   32'd15);
    chk("bp_mark_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 60 && fifo_count != 5'd0; i++)
      step();
    chk("bp_drained", 32'(fifo_count), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      exp_q.push_back(32'(i));
    exp_q.push_back(32'h80000011);
    chk_words("bp", exp_q);
    chk("bp_ts", 32'(timestep), 32'd1);

    // Reset while waiting in S_EOT with words queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("mr_eot_ready", 32'(bus.in_ready), 32'd0);
    chk("mr_count5",    32'(fifo_count),   32'd5);
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_count",     32'(fifo_count),    32'd0);
    chk("mr_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mr_overflow",  32'(overflow),      32'd0);
    chk("mr_ts",        32'(timestep),      32'd0);
    rst = 1'b0;
    got.delete();

    // Timestep wrap over 4096 empty passes.
    bus.out_ready = 1'b1;
    for (int p = 0; p < 4096; p++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    step();
    step();
    chk("wrap_ts",     32'(timestep),  32'd0);
    chk("wrap_nwords", 32'(got.size()), 32'd4096);
    chk("wrap_first",  (got.size() > 0)    ? got[0]    : 32'hDEADBEEF, 32'h80000000);
    chk("wrap_last",   (got.size() > 4095) ? got[4095] : 32'hDEADBEEF, 32'h8FFF0000);
    got.delete();

    // ts_clear keeps FIFO contents.
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("clr_ts_pre",    32'(timestep),   32'd1);
    chk("clr_count_pre", 32'(fifo_count), 32'd2);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk("clr_ts",    32'(timestep),   32'd0);
    chk("clr_count", 32'(fifo_count), 32'd2);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    chk("clr_drained", 32'(fifo_count), 32'd0);
    exp_q = '{32'h00000002, 32'h80000001};
    chk_words("clr", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_spike_aer_collector.md
Name: snn_spike_aer_collector

Overview:
- Downstream of the LIF neuron-update engine.
- Consumes the per-neuron spike decision emitted after each membrane write-back.
- Packs every spike into a 32-bit AER (address-event) word tagged with the current timestep, and buffers the words in a FWFT FIFO for the host/next layer.
- At the end of each layer pass it appends an end-of-timestep marker carrying the spike count, publishes the timestep's spike bitmap, and advances the timestep counter.

Parameters:
- NEURONS, 16, neurons per layer; width of the spike bitmap.
- IDX_W, 4, neuron index width; equals clog2(NEURONS).
- TS_W, 12, timestep counter width.
- DEPTH, 16, FIFO depth in words; power of two.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  neuron result present this cycle.
- in_ready  out  1  collector accepts a neuron result.
- in_neuron  in  IDX_W  index of the neuron just updated.
- in_spike  in  1  1 = neuron fired.
- layer_done  in  1  1-cycle pulse: last neuron of the pass delivered.
- ts_clear  in  1  zero the timestep counter and working bitmap/count.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_data  out  32  FIFO head word.
- spike_map  out  NEURONS  bitmap of the last completed timestep.
- map_valid  out  1  1-cycle pulse when spike_map updates.
- timestep  out  TS_W  current timestep.
- fifo_count  out  clog2(DEPTH)+1  words held.
- overflow  out  1  sticky: a spike event was dropped.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=S_RUN.
  - FIFO emptied: fifo_count=0, out_valid=0, out_data=0.
  - spike_map=0, map_valid=0, timestep=0, overflow=0.
  - Working bitmap and spike count cleared.
  - rst mid-operation discards any queued events and any pending marker.
- Word formats:
  - Spike word: {1'b0, 3'b000, timestep[11:0], 12'd0, neuron[3:0]}.
  - Marker word: {1'b1, 3'b000, timestep[11:0], spike_count[15:0]}.
- in_ready = (state==S_RUN).
- S_RUN:
  - An accepted result (in_valid && in_ready) with in_spike=1:
    - sets working bitmap bit in_neuron;
    - increments spike_count (saturates at 16'hFFFF);
    - pushes a spike word if fifo_count<DEPTH; otherwise drops the word and sets overflow (bitmap and count still update).
  - An accepted result with in_spike=0 has no effect.
  - Duplicate spikes from the same neuron in one timestep push two words; the bitmap bit stays 1 and the count increments twice.
  - layer_done=1 -> S_EOT next cycle. A result accepted in the same cycle is processed first and is included in the marker.
- S_EOT:
  - in_ready=0.
  - Marker push waits until fifo_count<DEPTH. A marker is never dropped.
  - On the push cycle:
    - spike_map<=working bitmap and map_valid=1 for exactly one cycle;
    - working bitmap and count cleared;
    - timestep increments, wrapping 4095->0;
    - -> S_RUN.
  - layer_done arriving while in S_EOT is ignored.
- ts_clear:
  - In S_RUN with layer_done=0: timestep, working bitmap and count <=0 next cycle.
  - Ignored in S_EOT or when layer_done=1.
  - Never flushes the FIFO.
- FIFO behaviour:
  - First-word fall-through. A word pushed at edge N is visible with out_valid=1 after edge N when the FIFO was empty (1-cycle latency).
  - Pop on out_valid && out_ready.
  - out_data=0 whenever out_valid=0.
  - Full means fifo_count==DEPTH. A push is refused when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow clears only on rst.

Test Plan:
- Basic events:
  - Stimulus: spikes from neurons 3, 7, 15 at timestep 0; out_ready=1; then layer_done.
  - Required: out_data sequence 0x00000003, 0x00000007, 0x0000000F, 0x80000003.
  - Required: spike_map=0x8088 with one map_valid pulse; timestep=1.
- Backpressure/full:
  - Stimulus: out_ready=0; 17 spiking results.
  - Required: fifo_count=16 and overflow=1 after the 17th.
  - Then layer_done: in_ready=0 and the design stays in S_EOT.
  - Then out_ready=1: the marker is pushed after the first pop with count field 17; all 16 stored spike words drain in order.
- Empty pass:
  - Stimulus: 16 results all with in_spike=0, then layer_done.
  - Required: single marker 0x80000000 (timestep 0), spike_map=0, timestep=1.
- Simultaneous events:
  - Stimulus: in_valid/in_spike for neuron 5 in the same cycle as layer_done.
  - Required: spike word pushed before the marker; marker count=1; spike_map bit 5=1.
- Wrap/clear:
  - Stimulus: 4096 empty passes.
  - Required: timestep wraps to 0 with the last marker showing 0xFFF.
  - Stimulus: ts_clear in S_RUN.
  - Required: timestep=0 next cycle and FIFO contents preserved.
- Reset mid-operation:
  - Stimulus: rst while in S_EOT with 5 words queued.
  - Required: next cycle out_valid=0, fifo_count=0, in_ready=1, overflow=0, timestep=0.
